tt_um_abdiskiosk_collatz_rev: RTL and testbench
===============================================

// Module: tt_um_abdiskiosk_collatz_rev
// PURPOSE
//  Reverse Collatz walker: the inverse direction of the team's forward Collatz step unit.
//  - Starts from an 8-bit seed and walks N steps backwards through the Collatz predecessor tree.
//  - A 3-bit path pattern picks the branch at each step: 2n, or (n-1)/3 where that branch is legal.
//  - The result, step count and status are read back over uo_out through a byte-select mux.
//  - Standalone TinyTapeout top, in the same chip as the forward step unit.
// PARAMETERS
//  WIDTH  16  internal value width; overflow is flagged at bit WIDTH-1
// PORTS
//  clk      in   1  single clock, all state on rising edge
//  rst_n    in   1  reset, synchronous, active-low
//  ena      in   1  ignored
//  ui_in    in   8  seed, latched on start
//  uio_in   in   8  [7]=start (rising edge), [6:5]=read select, [4:3]=N code, [2:0]=path pattern
//  uio_out  out  8  constant 8'h00
//  uio_oe   out  8  constant 8'h00 (all inputs)
//  uo_out   out  8  sel 00: value[7:0]; 01: value[15:8]; 10: {busy,done,ovf,oddcnt[4:0]};
//                   11: {3'b0,step[4:0]}
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge):
//    - state=IDLE; value, step, oddcnt, ovf, done all 0.
//    - start_q=1, so a start held high through reset does not trigger.
//    - uo_out reads 0 for every select code except sel=10, which reads 8'h00.
//  - States:
//    - IDLE: busy=0, done=0.
//    - RUN: busy=1.
//    - DONE: busy=0, done=1. Results are held until the next start.
//  - Start = uio_in[7] & ~start_q. It is accepted in IDLE or DONE only, and ignored in RUN.
//  - On an accepted start, capture:
//    - value={8'h00,ui_in}, path=uio_in[2:0], N=4*(uio_in[4:3]+1) (4,8,12,16).
//    - step=0, oddcnt=0, ovf=0, done=0; next state RUN.
//  - RUN, one step per cycle, using the bit b=path[step mod 3]:
//    - legal_odd = (value mod 6 == 4) && (value != 4). The 4 exclusion avoids the 1-4-2 cycle.
//    - If b && legal_odd: value <= (value-1)/3 (exact division) and oddcnt++.
//    - Else if value[WIDTH-1]: ovf<=1, value unchanged, step unchanged, next state DONE.
//    - Else: value <= value<<1.
//    - step++ on every non-overflow step. Go to DONE when the incremented step equals N.
//  - Seed 0 is legal; it stays 0 because 2*0=0.
//  - uo_out is a combinational mux of registered state. Sel changes are visible the same cycle.
//  - Latency: done asserts N cycles after the start edge is sampled, or earlier on overflow.
//  - Mid-run reset returns to IDLE on that edge. No partial result is retained.
// CONFIGURATION
//  COLLATZ_REV_ODDCNT_EN
//  - Defined: oddcnt counter is implemented and reported in status bits [4:0].
//  - Undefined: no counter is built, and status bits [4:0] read 0.
// STRUCTURE
//  - Package collatz_pkg holds:
//    - the WIDTH default;
//    - the state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
//    - the select codes SEL_LO, SEL_HI, SEL_STAT, SEL_STEP;
//    - the N-code decode.
//  - Sub-module collatz_rev_step (combinational): value, b -> next_value, took_odd, ovf.
//    It also contains the mod-6 test and the divide-by-3.
// TESTING
//  1. seed 16, path 000, N=4 -> value 0x0100; sel00 reads 0x00, sel01 reads 0x01;
//     status=0x40, step=4; done 4 cycles after start.
//  2. seed 16, path 001, N=4 -> walk 16,5,10,20,40; result 40, oddcnt=1 (status 0x41 when EN).
//  3. seed 4, path 111, N=4 -> walk 4,8,16,5,10; the 4 exclusion is honoured; result 10, oddcnt=1.
//  4. seed 255, path 000, N=12 -> overflow at value 0xFF00; ovf=1, step=8, value held 0xFF00,
//     status 0x60.
//  5. start pulse during RUN -> ignored.
//     Start in DONE with seed 3, path 000, N=4 -> result 48.
//  6. rst_n low in RUN at step 2 -> IDLE, all outputs 0.
//     start held high through reset -> no run until start falls and rises again.

Source files
------------

// File: rtl/collatz_pkg.sv
// Shared types and constants for the reverse Collatz walker.
package collatz_pkg;

   localparam int WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SEL_LO   = 2'd0,
      SEL_HI   = 2'd1,
      SEL_STAT = 2'd2,
      SEL_STEP = 2'd3
   } sel_t;

   // N code 0..3 selects a walk length of 4, 8, 12 or 16 steps.
   function automatic logic [4:0] decodeN(input logic [1:0] code);
      return 5'({code, 2'b00}) + 5'd4;
   endfunction

endpackage

// File: rtl/collatz_rev_if.sv
// Datapath hookup between the walker control and its combinational step unit.
interface collatz_rev_if;
   import collatz_pkg::*;

   logic [WIDTH-1:0] value;
   logic             pathBit;
   logic [WIDTH-1:0] nextValue;
   logic             tookOdd;
   logic             ovf;

   modport master (output value, pathBit, input nextValue, tookOdd, ovf);
   modport slave  (input value, pathBit, output nextValue, tookOdd, ovf);

endinterface

// File: rtl/collatz_rev_step.sv
// One backward Collatz step: take the (n-1)/3 branch when requested and legal,
// otherwise double, flagging overflow when the top bit is already set.
module collatz_rev_step
   import collatz_pkg::*;
(
   collatz_rev_if.slave stepIf
);

   logic             legalOdd;
   logic [WIDTH-1:0] predOdd;

   // 4 is excluded so the walk never re-enters the 1-4-2 loop.
   assign legalOdd = (stepIf.value % WIDTH'(6) == WIDTH'(4)) && (stepIf.value != WIDTH'(4));
   assign predOdd  = (stepIf.value - WIDTH'(1)) / WIDTH'(3);

   always_comb begin
      stepIf.nextValue = stepIf.value;
      stepIf.tookOdd   = 1'b0;
      stepIf.ovf       = 1'b0;
      if (stepIf.pathBit && legalOdd) begin
         stepIf.nextValue = predOdd;
         stepIf.tookOdd   = 1'b1;
      end else if (stepIf.value[WIDTH-1]) begin
         stepIf.ovf = 1'b1;
      end else begin
         stepIf.nextValue = {stepIf.value[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/tt_um_abdiskiosk_collatz_rev.sv
// Reverse Collatz walker TinyTapeout top. Define COLLATZ_REV_ODDCNT_EN to build
// the odd-branch counter reported in the status byte.
module tt_um_abdiskiosk_collatz_rev
   import collatz_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   output logic [7:0] uo_out
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic [4:0]       step_q, step_d;
   logic [4:0]       n_q, n_d;
   logic [2:0]       path_q, path_d;
   logic [1:0]       phase_q, phase_d;
   logic             ovf_q, ovf_d;
   logic             start_q;
   logic             accept;
   logic [4:0]       oddcnt;
   logic             unusedEna;

   collatz_rev_if stepIf ();

   collatz_rev_step uStep (.stepIf(stepIf));

   assign stepIf.value   = value_q;
   assign stepIf.pathBit = path_q[phase_q];

   assign accept    = uio_in[7] && !start_q && (state_q != RUN);
   assign uio_out   = 8'h00;
   assign uio_oe    = 8'h00;
   assign unusedEna = ena;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         value_q <= '0;
         step_q  <= '0;
         n_q     <= '0;
         path_q  <= '0;
         phase_q <= '0;
         ovf_q   <= 1'b0;
         start_q <= 1'b1;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         step_q  <= step_d;
         n_q     <= n_d;
         path_q  <= path_d;
         phase_q <= phase_d;
         ovf_q   <= ovf_d;
         start_q <= uio_in[7];
      end
   end

   // phase tracks step mod 3 so the path bit needs no divider.
   always_comb begin
      state_d = state_q;
      value_d = value_q;
      step_d  = step_q;
      n_d     = n_q;
      path_d  = path_q;
      phase_d = phase_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               value_d = {{(WIDTH-8){1'b0}}, ui_in};
               path_d  = uio_in[2:0];
               n_d     = decodeN(uio_in[4:3]);
               step_d  = '0;
               phase_d = '0;
               ovf_d   = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (stepIf.ovf) begin
               ovf_d   = 1'b1;
               state_d = DONE;
            end else begin
               value_d = stepIf.nextValue;
               step_d  = step_q + 5'd1;
               phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
               if (step_q + 5'd1 == n_q) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef COLLATZ_REV_ODDCNT_EN
   logic [4:0] oddcnt_q, oddcnt_d;

   always_ff @(posedge clk) begin
      if (!rst_n) oddcnt_q <= '0;
      else        oddcnt_q <= oddcnt_d;
   end

   always_comb begin
      oddcnt_d = oddcnt_q;
      if (accept)                                     oddcnt_d = '0;
      else if ((state_q == RUN) && stepIf.tookOdd)    oddcnt_d = oddcnt_q + 5'd1;
   end

   assign oddcnt = oddcnt_q;
`else
   logic unusedTookOdd;
   assign unusedTookOdd = stepIf.tookOdd;
   assign oddcnt        = '0;
`endif

   always_comb begin
      uo_out = 8'h00;
      case (sel_t'(uio_in[6:5]))
         SEL_LO:   uo_out = value_q[7:0];
         SEL_HI:   uo_out = value_q[15:8];
         SEL_STAT: uo_out = {state_q == RUN, state_q == DONE, ovf_q, oddcnt};
         SEL_STEP: uo_out = {3'b000, step_q};
         default:  uo_out = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_tt_um_abdiskiosk_collatz_rev.sv
// Self-checking bench for the reverse Collatz walker: directed cases plus random
// walks compared against an arithmetic reference model.
module tb_tt_um_abdiskiosk_collatz_rev;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic [7:0] uo_out;

   int compared   = 0;
   int mismatched = 0;

`ifdef COLLATZ_REV_ODDCNT_EN
   localparam bit ODD_EN = 1'b1;
`else
   localparam bit ODD_EN = 1'b0;
`endif

   tt_um_abdiskiosk_collatz_rev dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .uo_out  (uo_out)
   );

   always #5 clk = ~clk;

   // Compare one observed byte/count against the expected value.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic readSel(input logic [1:0] sel, output int data);
      uio_in[6:5] = sel;
      #1;
      data = int'(uo_out);
   endtask

   task automatic checkSel(input string tag, input logic [1:0] sel, input int expected);
      int d;
      readSel(sel, d);
      checkOutput(tag, d, expected);
   endtask

   function automatic int statByte(input int busy, input int done, input int ovf, input int odd);
      return (busy << 7) | (done << 6) | (ovf << 5) | (ODD_EN ? (odd & 31) : 0);
   endfunction

   // Walk the predecessor tree with plain integer arithmetic.
   task automatic refModel(input int seed, input int path, input int n,
                           output int v, output int st, output int od,
                           output int ov, output int cyc);
      int b;
      v = seed; st = 0; od = 0; ov = 0;
      while (st < n) begin
         b = (path >> (st % 3)) & 1;
         if (b == 1 && v % 6 == 4 && v != 4) begin
            v = (v - 1) / 3;
            od++;
         end else if (v >= 32768) begin
            ov = 1;
            break;
         end else begin
            v = v * 2;
         end
         st++;
      end
      cyc = (ov == 1) ? st + 1 : n;
   endtask

   // Count cycles until done, with a hard bound so a stuck design still ends.
   task automatic waitDone(output int cycles);
      int d;
      cycles = 0;
      while (cycles < 64) begin
         @(posedge clk);
         cycles++;
         readSel(2'b10, d);
         if (d[6]) break;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] seed, input logic [2:0] path,
                                input logic [1:0] ncode, output int cycles);
      @(negedge clk);
      ui_in  = seed;
      uio_in = {1'b1, 2'b10, ncode, path};
      @(posedge clk);
      #1;
      uio_in[7] = 1'b0;
      waitDone(cycles);
   endtask

   task automatic runAndCheck(input string tag, input logic [7:0] seed,
                              input logic [2:0] path, input logic [1:0] ncode);
      int cycles, v, st, od, ov, cyc;
      applyStimulus(seed, path, ncode, cycles);
      refModel(int'(seed), int'(path), 4 * (int'(ncode) + 1), v, st, od, ov, cyc);
      @(negedge clk);
      checkOutput({tag, ".cycles"}, cycles, cyc);
      checkSel({tag, ".lo"},   2'b00, v & 255);
      checkSel({tag, ".hi"},   2'b01, (v >> 8) & 255);
      checkSel({tag, ".stat"}, 2'b10, statByte(0, 1, ov, od));
      checkSel({tag, ".step"}, 2'b11, st);
   endtask

   initial begin
      int cycles, v, st, od, ov, cyc, d;
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] reset state");
      for (int s = 0; s < 4; s++) checkSel($sformatf("reset.sel%0d", s), 2'(s), 0);
      checkOutput("uio_out", int'(uio_out), 0);
      checkOutput("uio_oe",  int'(uio_oe),  0);

      $display("[TB] directed walks");
      runAndCheck("t1_seed16_p000", 8'd16, 3'b000, 2'd0);
      checkSel("t1.lo_const",   2'b00, 8'h00);
      checkSel("t1.hi_const",   2'b01, 8'h01);
      checkSel("t1.stat_const", 2'b10, 8'h40);
      runAndCheck("t2_seed16_p001", 8'd16, 3'b001, 2'd0);
      checkSel("t2.lo_const", 2'b00, 40);
      runAndCheck("t3_seed4_p111", 8'd4, 3'b111, 2'd0);
      checkSel("t3.lo_const", 2'b00, 10);
      runAndCheck("t4_seed255_ovf", 8'd255, 3'b000, 2'd2);
      checkSel("t4.hi_const",   2'b01, 8'hFF);
      checkSel("t4.stat_const", 2'b10, 8'h60);
      checkSel("t4.step_const", 2'b11, 8);
      runAndCheck("seed0", 8'd0, 3'b111, 2'd3);

      $display("[TB] start during run is ignored");
      @(negedge clk);
      ui_in  = 8'd16;
      uio_in = {1'b1, 2'b10, 2'd3, 3'b000};
      @(posedge clk);
      #1;
      uio_in[7] = 1'b0;
      @(negedge clk);
      ui_in = 8'd99;
      uio_in[7] = 1'b1;
      @(negedge clk);
      uio_in[7] = 1'b0;
      waitDone(cycles);
      refModel(16, 0, 16, v, st, od, ov, cyc);
      @(negedge clk);
      checkSel("t5.lo",   2'b00, v & 255);
      checkSel("t5.hi",   2'b01, (v >> 8) & 255);
      checkSel("t5.stat", 2'b10, statByte(0, 1, ov, od));
      runAndCheck("t5_restart_seed3", 8'd3, 3'b000, 2'd0);
      checkSel("t5.lo_const", 2'b00, 48);

      $display("[TB] mid-run reset and start held through reset");
      @(negedge clk);
      ui_in  = 8'd7;
      uio_in = {1'b1, 2'b10, 2'd3, 3'b000};
      @(posedge clk);
      #1;
      uio_in[7] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkSel("t6.midstep", 2'b11, 2);
      rst_n     = 1'b0;
      uio_in[7] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 4; s++) checkSel($sformatf("t6.reset.sel%0d", s), 2'(s), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkSel("t6.held.stat", 2'b10, 0);
      checkSel("t6.held.step", 2'b11, 0);
      uio_in[7] = 1'b0;
      runAndCheck("t6_after_release", 8'd7, 3'b010, 2'd1);

      $display("[TB] random walks");
      for (int i = 0; i < 24; i++) begin
         runAndCheck($sformatf("rand%0d", i), 8'($urandom), 3'($urandom_range(7, 0)),
                     2'($urandom_range(3, 0)));
      end

      readSel(2'b10, d);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
